sc_upcount_scheduler: RTL and testbench

Round-robin scheduler that shares one up-transition counter between several game-event requesters, such as goal reached, bonus collected, or timer tick. It captures active-low request edges and grants one requester at a time. For each grant it issues a single-cycle active-low upcount strobe and a clear strobe to the counter, and watches the counter's output bus for a terminal value. It sits between the Frogger game-logic event sources and the counter instance that drives the score/level display.

---
 rtl/sc_upcount_scheduler_pkg.sv | 7 +
 rtl/sc_upsched_rr_arbiter.sv | 25 ++
 rtl/sc_upcount_scheduler.sv | 89 ++++++++
 tb/tb_sc_upcount_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sc_upcount_scheduler_pkg.sv
// sc_upcount_scheduler_pkg: shared state encoding and default sizing for the upcount scheduler.
package sc_upcount_scheduler_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, WAIT = 2'd2, CLEAR = 2'd3} state_t;
  localparam int NREQ_DEF = 4;
  localparam int DATAWIDTH_DEF = 8;
  localparam int TERMINAL_COUNT_DEF = 5;
endpackage

// File: rtl/sc_upsched_rr_arbiter.sv
// sc_upsched_rr_arbiter: combinational round-robin pick, searching from last_grant+1 modulo NREQ.
import sc_upcount_scheduler_pkg::*;
module sc_upsched_rr_arbiter #(
  parameter int NREQ = NREQ_DEF,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] pending,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic            valid
);
  logic [IW-1:0] idx;
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NREQ);
      if (!valid && pending[idx]) begin
        grant[idx] = 1'b1;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sc_upcount_scheduler.sv
// sc_upcount_scheduler: shares one up-transition counter among NREQ requesters (round-robin).
// Define SC_UPSCHED_SYNC_EN to pass each request bit through a 2-flop synchronizer.
import sc_upcount_scheduler_pkg::*;
module sc_upcount_scheduler #(
  parameter int NREQ = NREQ_DEF,
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int TERMINAL_COUNT = TERMINAL_COUNT_DEF,
  parameter int IW = $clog2(NREQ)
) (
  input  logic                 SC_upTRANSITIONCOUNTER_CLOCK_50,
  input  logic                 SC_upTRANSITIONCOUNTER_RESET_InHigh,
  input  logic [NREQ-1:0]      SC_UPSCHED_req_InLow,
  input  logic                 SC_UPSCHED_clear_InLow,
  input  logic [DATAWIDTH-1:0] SC_UPSCHED_count_InBUS,
  output logic                 SC_UPSCHED_upcount_OutLow,
  output logic                 SC_UPSCHED_clear_OutLow,
  output logic [NREQ-1:0]      SC_UPSCHED_grant_OutBUS,
  output logic                 SC_UPSCHED_terminal_OutHigh,
  output logic                 SC_UPSCHED_busy_OutHigh
);
  state_t state_q, state_d;
  logic [NREQ-1:0] req_s, req_prev_q, fall, pending_q, pending_d, grant_q, grant_d, arb_grant;
  logic [IW-1:0] last_q, last_d, gidx;
  logic upcount_q, upcount_d, clear_q, clear_d, terminal_q, terminal_d, arb_valid, go;
`ifdef SC_UPSCHED_SYNC_EN
  logic [NREQ-1:0] sync1_q, sync2_q;
  always_ff @(posedge SC_upTRANSITIONCOUNTER_CLOCK_50 or posedge SC_upTRANSITIONCOUNTER_RESET_InHigh) begin
    if (SC_upTRANSITIONCOUNTER_RESET_InHigh) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= SC_UPSCHED_req_InLow;
      sync2_q <= sync1_q;
    end
  end
  assign req_s = sync2_q;
`else
  assign req_s = SC_UPSCHED_req_InLow;
`endif
  assign fall = req_prev_q & ~req_s;
  sc_upsched_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .pending(pending_q),
    .last_grant(last_q),
    .grant(arb_grant),
    .valid(arb_valid)
  );
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) if (arb_grant[i]) gidx = IW'(i);
    state_d = state_q == IDLE ? (!SC_UPSCHED_clear_InLow ? CLEAR :
              (arb_valid && !terminal_q && SC_UPSCHED_count_InBUS != '1) ? GRANT : IDLE) :
              state_q == GRANT ? WAIT : IDLE;
    go = state_d == GRANT;
    // A new edge always survives the grant or flush of its own flag
    pending_d = state_d == CLEAR ? fall : (pending_q & ~(go ? arb_grant : '0)) | fall;
    last_d = go ? gidx : last_q;
    grant_d = go ? arb_grant : '0;
    upcount_d = ~go;
    clear_d = state_d != CLEAR;
    terminal_d = state_d == CLEAR ? 1'b0 :
                 (state_q == WAIT && SC_UPSCHED_count_InBUS >= DATAWIDTH'(TERMINAL_COUNT)) ? 1'b1 : terminal_q;
  end
  always_ff @(posedge SC_upTRANSITIONCOUNTER_CLOCK_50 or posedge SC_upTRANSITIONCOUNTER_RESET_InHigh) begin
    if (SC_upTRANSITIONCOUNTER_RESET_InHigh) begin
      state_q <= IDLE;
      req_prev_q <= '1;
      pending_q <= '0;
      last_q <= IW'(NREQ - 1);
      grant_q <= '0;
      upcount_q <= 1'b1;
      clear_q <= 1'b1;
      terminal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_prev_q <= req_s;
      pending_q <= pending_d;
      last_q <= last_d;
      grant_q <= grant_d;
      upcount_q <= upcount_d;
      clear_q <= clear_d;
      terminal_q <= terminal_d;
    end
  end
  assign SC_UPSCHED_upcount_OutLow = upcount_q;
  assign SC_UPSCHED_clear_OutLow = clear_q;
  assign SC_UPSCHED_grant_OutBUS = grant_q;
  assign SC_UPSCHED_terminal_OutHigh = terminal_q;
  assign SC_UPSCHED_busy_OutHigh = state_q != IDLE || |pending_q;
endmodule

// File: tb/tb_sc_upcount_scheduler.sv
// tb_sc_upcount_scheduler: random request bursts against a round-robin/counter reference model.
module tb_sc_upcount_scheduler;
  localparam int NREQ = 4;
  localparam int DW = 8;
  localparam int TC = 5;
`ifdef SC_UPSCHED_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req = '1;
  logic clr_in = 1'b1;
  logic [DW-1:0] cnt = '0;
  logic ld = 1'b0;
  logic [DW-1:0] ld_val = '0;
  logic up_out, clr_out, term, busy;
  logic [NREQ-1:0] grant;
  int up_pulses = 0;
  int n_checks = 0;
  int n_fail = 0;
  int last_g = NREQ - 1;
  sc_upcount_scheduler #(.NREQ(NREQ), .DATAWIDTH(DW), .TERMINAL_COUNT(TC)) dut (
    .SC_upTRANSITIONCOUNTER_CLOCK_50(clk),
    .SC_upTRANSITIONCOUNTER_RESET_InHigh(rst),
    .SC_UPSCHED_req_InLow(req),
    .SC_UPSCHED_clear_InLow(clr_in),
    .SC_UPSCHED_count_InBUS(cnt),
    .SC_UPSCHED_upcount_OutLow(up_out),
    .SC_UPSCHED_clear_OutLow(clr_out),
    .SC_UPSCHED_grant_OutBUS(grant),
    .SC_UPSCHED_terminal_OutHigh(term),
    .SC_UPSCHED_busy_OutHigh(busy)
  );
  always #10 clk = ~clk;
  // external up-transition counter driven by the scheduler's strobes
  always @(posedge clk) begin
    if (ld) cnt <= ld_val;
    else if (!clr_out) cnt <= '0;
    else if (!up_out) cnt <= cnt + 1'b1;
    if (!up_out) up_pulses <= up_pulses + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic burst(input logic [NREQ-1:0] m);
    int q[$];
    int t, tg, w, idx;
    logic [DW-1:0] c0;
    for (int o = 1; o <= NREQ; o++) if (m[(last_g + o) % NREQ]) q.push_back((last_g + o) % NREQ);
    @(negedge clk);
    c0 = cnt;
    req = ~m;
    t = 0;
    tg = -1;
    @(negedge clk);
    req = '1;
    t = 1;
    while (q.size() > 0) begin
      idx = q.pop_front();
      w = 0;
      do begin
        @(negedge clk);
        t++;
        w++;
      end while (up_out && w < 12);
      if (up_out) begin
        check("grant_timeout", up_out, 0);
        return;
      end
      check("grant", grant, 32'(1) << idx);
      check(tg < 0 ? "latency" : "spacing", tg < 0 ? t : t - tg, tg < 0 ? LAT : 3);
      tg = t;
      last_g = idx;
      @(negedge clk);
      t++;
      check("upcount_width", up_out, 1);
    end
    @(negedge clk);
    check("busy_after", busy, 0);
    check("count_after", cnt, 32'(c0) + $countones(m));
    check("terminal", term, 32'(cnt >= DW'(TC)));
  endtask
  task automatic do_clear();
    @(negedge clk);
    clr_in = 1'b0;
    @(negedge clk);
    clr_in = 1'b1;
    check("clear_low", clr_out, 0);
    @(negedge clk);
    check("clear_width", clr_out, 1);
    check("terminal_cleared", term, 0);
    check("count_cleared", cnt, 0);
    check("busy_cleared", busy, 0);
  endtask
  task automatic edge_no_grant(input int bitn, input logic [DW-1:0] exp_cnt);
    int p;
    p = up_pulses;
    @(negedge clk);
    req = ~(NREQ'(1) << bitn);
    @(negedge clk);
    req = '1;
    repeat (10) @(negedge clk);
    check("no_upcount", up_pulses - p, 0);
    check("count_held", cnt, exp_cnt);
    check("busy_pending", busy, 1);
  endtask
  initial begin
    int p, w;
    logic [DW-1:0] c;
    repeat (3) @(negedge clk);
    check("rst_upcount", up_out, 1);
    check("rst_clear", clr_out, 1);
    check("rst_grant", grant, 0);
    check("rst_terminal", term, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    burst(4'b1011);
    do_clear();
    burst(4'b0100);
    repeat (8) begin
      do_clear();
      burst(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
    end
    do_clear();
    repeat (5) burst(NREQ'(1) << $urandom_range(0, NREQ - 1));
    check("terminal_set", term, 1);
    edge_no_grant(0, DW'(TC));
    do_clear();
    @(negedge clk);
    ld_val = '1;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    edge_no_grant(1, '1);
    do_clear();
    @(negedge clk);
    req = 4'b0111;
    @(negedge clk);
    req = '1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (up_out && w < 12);
    check("pre_reset_grant", grant, 4'b1000);
    #2 rst = 1'b1;
    #1;
    check("async_upcount", up_out, 1);
    check("async_grant", grant, 0);
    check("async_busy", busy, 0);
    check("async_clear", clr_out, 1);
    check("async_terminal", term, 0);
    c = cnt;
    p = up_pulses;
    @(negedge clk);
    rst = 1'b0;
    last_g = NREQ - 1;
    repeat (8) @(negedge clk);
    check("no_spurious_upcount", up_pulses - p, 0);
    check("count_after_reset", cnt, c);
    burst(4'b0110);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
